tape_mem_arbiter: RTL and testbench

- Shares the single-port, byte-wide data-tape RAM between three users: the CPU core's read/write port, the VGA scan reader, and a built-in clear engine that zeroes the whole tape.
- Sits between the CPU core, the VGA cell fetch and one `tape_spram` instance.
- Replaces the dual-port tape memory and the CPU's own zeroing state.
- Guarantees VGA a bounded wait; otherwise favours the CPU.

---
 rtl/tape_pkg.sv | 20 ++
 rtl/tape_spram.sv | 28 ++
 rtl/tape_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_tape_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the data-tape memory subsystem.
// Holds the arbiter FSM state encodings, default tape geometry and the
// encoding of which user currently drives the RAM port.
package tape_pkg;

  localparam int TAPE_ADDR_WIDTH = 12;
  localparam int TAPE_DATA_WIDTH = 8;

  // Arbiter FSM states
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  // RAM port owner for the current cycle
  typedef logic [1:0] gsel_t;
  localparam gsel_t GSEL_NONE = 2'd0;
  localparam gsel_t GSEL_CPU  = 2'd1;
  localparam gsel_t GSEL_VGA  = 2'd2;
  localparam gsel_t GSEL_CLR  = 2'd3;

endpackage

// File: rtl/tape_spram.sv
// Single-port synchronous tape RAM, read-first, one-cycle read latency.
// Ports:
//   clk   - clock
//   we    - write enable
//   addr  - cell address
//   wdata - write data
//   rdata - data of the address presented on the previous edge
module tape_spram
  import tape_pkg::*;
#(
  parameter int ADDR_WIDTH = TAPE_ADDR_WIDTH,
  parameter int DATA_WIDTH = TAPE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/tape_mem_arbiter.sv
// Arbiter for the single-port data-tape RAM.
// Three users share the port: the CPU read/write port, the VGA cell reader
// and an internal clear engine that zeroes the whole tape. The CPU is
// favoured, but a pending VGA request can be refused at most VGA_MAX_WAIT
// consecutive cycles before it wins.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   clear_req / clear_busy     - start a full tape clear / clear in progress
//   cpu_req/we/addr/wdata      - CPU request, held until cpu_gnt
//   cpu_gnt/rvalid/rdata       - CPU accept strobe and read return
//   vga_req/addr               - VGA read request, held until vga_gnt
//   vga_gnt/rvalid/rdata       - VGA accept strobe and read return
//   mem_we/addr/wdata/rdata    - RAM port (rdata one cycle after addr)
module tape_mem_arbiter
  import tape_pkg::*;
#(
  parameter int ADDR_WIDTH     = TAPE_ADDR_WIDTH,
  parameter int DATA_WIDTH     = TAPE_DATA_WIDTH,
  parameter int VGA_MAX_WAIT   = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  clear_busy,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_gnt,
  output logic                  vga_rvalid,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WAIT_W = (VGA_MAX_WAIT < 1) ? 1 : $clog2(VGA_MAX_WAIT + 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clear_ptr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [WAIT_W-1:0]     vga_wait;
  logic                  in_idle;
  logic                  vga_pri;
  gsel_t                 gsel;

  assign in_idle    = (state == S_IDLE);
  assign clear_busy = (state == S_CLEAR);
  // VGA has been starved long enough to pre-empt the CPU
  assign vga_pri    = (vga_wait >= WAIT_W'(VGA_MAX_WAIT));

  assign cpu_gnt = in_idle && cpu_req && !(vga_req && vga_pri);
  assign vga_gnt = in_idle && vga_req && (!cpu_req || vga_pri);

  // Both read ports see the RAM output; rvalid alone says whose data it is.
  assign cpu_rdata = mem_rdata;
  assign vga_rdata = mem_rdata;

  always_comb begin
    gsel = GSEL_NONE;
    if (clear_busy)   gsel = GSEL_CLR;
    else if (cpu_gnt) gsel = GSEL_CPU;
    else if (vga_gnt) gsel = GSEL_VGA;
  end

  // With no owner the address holds its previous value so the RAM address
  // bus does not toggle on idle cycles.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = last_addr;
    mem_wdata = '0;
    case (gsel)
      GSEL_CLR: begin
        mem_we   = 1'b1;
        mem_addr = clear_ptr;
      end
      GSEL_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      GSEL_VGA: mem_addr = vga_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clear_ptr  <= '0;
      vga_wait   <= '0;
      cpu_rvalid <= 1'b0;
      vga_rvalid <= 1'b0;
      last_addr  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      vga_rvalid <= vga_gnt;
      if (gsel != GSEL_NONE) last_addr <= mem_addr;
      case (state)
        S_IDLE: begin
          if (clear_req) state <= S_CLEAR;
          if (!vga_req || vga_gnt) vga_wait <= '0;
          else if (!vga_pri)       vga_wait <= vga_wait + WAIT_W'(1);
        end
        S_CLEAR: begin
          // clear_req is ignored here; the wrap back to 0 ends the pass
          clear_ptr <= clear_ptr + ADDR_WIDTH'(1);
          if (clear_ptr == '1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Self-checking bench for tape_mem_arbiter with a tape_spram beside it.
module tb_tape_mem_arbiter;
  import tape_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 4096;
  localparam int MAXW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_req, clear_busy;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          vga_req, vga_gnt, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // bench-side preload path into the RAM
  logic          pre_en, pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_wdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  assign ram_we    = pre_en ? pre_we    : mem_we;
  assign ram_addr  = pre_en ? pre_addr  : mem_addr;
  assign ram_wdata = pre_en ? pre_wdata : mem_wdata;

  always #5 clk = ~clk;

  tape_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VGA_MAX_WAIT(MAXW),
                     .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  tape_spram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(mem_rdata)
  );

  // reference model
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clear_left;   // cycles of clearing still to come
  int            m_denied;       // consecutive refusals of a pending VGA request
  bit            m_cpu_rv, m_vga_rv;
  logic [DW-1:0] m_cpu_rd, m_vga_rd;
  logic [AW-1:0] m_last_addr;
  bit            g_cpu, g_vga;
  int            busy_cnt;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with full checking. Inputs are set by the caller just after
  // the previous rising edge; outputs are sampled at the falling edge.
  task automatic cycle();
    bit            busy, ec, ev, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    busy = (m_clear_left > 0);
    ev   = !busy && vga_req && (!cpu_req || m_denied >= MAXW);
    ec   = !busy && cpu_req && !ev;
    ewe  = 1'b0;
    ed   = '0;
    ea   = m_last_addr;
    if (busy)    begin ewe = 1'b1; ea = AW'(DEPTH - m_clear_left); end
    else if (ec) begin ewe = cpu_we; ea = cpu_addr; if (cpu_we) ed = cpu_wdata; end
    else if (ev) ea = vga_addr;

    chk("clear_busy", clear_busy, busy);
    chk("cpu_gnt", cpu_gnt, ec);
    chk("vga_gnt", vga_gnt, ev);
    chk("cpu_rvalid", cpu_rvalid, m_cpu_rv);
    chk("vga_rvalid", vga_rvalid, m_vga_rv);
    if (m_cpu_rv) chk("cpu_rdata", cpu_rdata, m_cpu_rd);
    if (m_vga_rv) chk("vga_rdata", vga_rdata, m_vga_rd);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    if (ewe) chk("mem_wdata", mem_wdata, ed);

    m_cpu_rv = ec && !cpu_we;
    m_cpu_rd = m_mem[cpu_addr];
    m_vga_rv = ev;
    m_vga_rd = m_mem[vga_addr];
    if (busy || ec || ev) m_last_addr = ea;
    if (ewe) m_mem[ea] = ed;
    if (busy) begin
      m_clear_left--;
      busy_cnt++;
    end else begin
      if (clear_req) m_clear_left = DEPTH;
      if (vga_req && !ev) m_denied = (m_denied < MAXW) ? m_denied + 1 : MAXW;
      else                m_denied = 0;
    end
    g_cpu = ec;
    g_vga = ev;
    @(posedge clk); #1;
    if (ec) cpu_req = 1'b0;
    if (ev) vga_req = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset        = 1'b0;
    cpu_req      = 1'b0;
    vga_req      = 1'b0;
    m_clear_left = DEPTH;
    m_denied     = 0;
    m_cpu_rv     = 1'b0;
    m_vga_rv     = 1'b0;
    m_last_addr  = '0;
  endtask

  task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    cycle();
  endtask

  initial begin
    reset = 1'b1; clear_req = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    pre_en = 1'b1; pre_we = 1'b1; pre_addr = '0; pre_wdata = 8'hAA;

    // fill the tape with 0xAA while the arbiter sits in reset
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      pre_addr = AW'(i);
      m_mem[i] = 8'hAA;
    end
    @(posedge clk); #1;
    pre_en = 1'b0; pre_we = 1'b0;
    do_reset(2);

    // clear after reset: exactly DEPTH busy cycles, no grants
    chk("reset_busy", clear_busy, 1'b1);
    chk("reset_cpu_rvalid", cpu_rvalid, 1'b0);
    busy_cnt = 0;
    cpu_req = 1'b1; vga_req = 1'b1; cpu_addr = 12'h123; vga_addr = 12'h010;
    run(DEPTH + 4);
    chk("reset_clear_len", busy_cnt, DEPTH);
    cpu_op(1'b0, 12'h123, 8'h00);
    chk("rd123_after_clear", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h00});

    // write then read back
    cpu_op(1'b1, 12'd7, 8'h5C);
    chk("wr7_no_rvalid", cpu_rvalid, 1'b0);
    cpu_op(1'b0, 12'd7, 8'h00);
    chk("rd7", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h5C});
    run(2);

    // both held: CPU x4 then VGA x1, repeating
    for (int k = 0; k < 20; k++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(k);
      vga_req = 1'b1; vga_addr = AW'(k + 100);
      cycle();
      chk("pattern_vga", g_vga, (k % 5) == 4);
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    run(2);

    // VGA-only read of the top cell
    cpu_op(1'b1, 12'hFFF, 8'h33);
    vga_req = 1'b1; vga_addr = 12'hFFF;
    cycle();
    chk("vga_fff_gnt", g_vga, 1'b1);
    chk("vga_fff", {vga_rvalid, vga_rdata}, {1'b1, 8'h33});
    chk("vga_fff_cpu_rv", cpu_rvalid, 1'b0);
    run(1);

    // clear request coinciding with a granted CPU read
    cpu_op(1'b1, 12'd2, 8'h77);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd2; clear_req = 1'b1;
    busy_cnt = 0;
    cycle();
    chk("preclear_rd2", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h77});
    chk("clear_rises", clear_busy, 1'b1);
    run(100);
    clear_req = 1'b1;               // ignored mid-clear
    run(DEPTH);
    chk("clear_req_len", busy_cnt, DEPTH);
    cpu_op(1'b0, 12'd2, 8'h00);
    chk("rd2_after_clear", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h00});

    // reset during a granted read drops its rvalid
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd3;
    do_reset(1);
    chk("reset_drops_rvalid", cpu_rvalid, 1'b0);
    // reset mid-clear restarts from address 0
    run(1000);
    @(negedge clk);
    chk("ptr_1000", mem_addr, 12'd1000);
    @(posedge clk); #1;
    do_reset(1);
    chk("restart_addr0", mem_addr, 12'd0);
    busy_cnt = 0;
    run(DEPTH + 4);
    chk("restart_clear_len", busy_cnt, DEPTH);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (!cpu_req && $urandom_range(0, 2) != 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = ($urandom_range(0, 7) == 0) ? 12'hFFF : AW'($urandom_range(0, 15));
        cpu_wdata = DW'($urandom);
      end
      if (!vga_req && $urandom_range(0, 2) != 0) begin
        vga_req  = 1'b1;
        vga_addr = ($urandom_range(0, 7) == 0) ? 12'hFFF : AW'($urandom_range(0, 15));
      end
      clear_req = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
